bk_accum: RTL and testbench

BK_ACCUM -- requirements
Module: bk_accum

---
 rtl/bk_pkg.sv | 13 +
 rtl/BrentKung_par.sv | 48 ++++
 rtl/bk_accum.sv | 112 +++++++++++
 tb/tb_bk_accum.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung frame accumulator: FSM encoding and default widths.
package bk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BK_N   = 16;
    localparam int BK_LEN = 8;

endpackage

// File: rtl/BrentKung_par.sv
// Parameterised Brent-Kung parallel-prefix adder: Sum = A + B + Cin, Cout is the carry out of bit N-1.
module BrentKung_par #(
    parameter int N = 16
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    // Largest power of two below N; the down-sweep starts from this span.
    localparam int TOP = 2 ** ($clog2(N) - 1);

    logic [N-1:0] p_s;
    logic [N-1:0] g_s;
    logic [N-1:0] gp_s;
    logic [N-1:0] pp_s;
    logic [N-1:0] c_s;

    // Prefix tree: up-sweep builds power-of-two spans, down-sweep fills the remaining prefixes.
    always_comb begin
        p_s  = A ^ B;
        g_s  = A & B;
        gp_s = g_s;
        pp_s = p_s;
        c_s  = {N{1'b0}};
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
                gp_s[i] = gp_s[i] | (pp_s[i] & gp_s[i - d]);
                pp_s[i] = pp_s[i] & pp_s[i - d];
            end
        end
        for (int d = TOP; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
                gp_s[i] = gp_s[i] | (pp_s[i] & gp_s[i - d]);
                pp_s[i] = pp_s[i] & pp_s[i - d];
            end
        end
        c_s[0] = Cin;
        for (int i = 1; i < N; i++) begin
            c_s[i] = gp_s[i - 1] | (pp_s[i - 1] & Cin);
        end
        Sum  = p_s ^ c_s;
        Cout = gp_s[N - 1] | (pp_s[N - 1] & Cin);
    end

endmodule

// File: rtl/bk_accum.sv
// Frame accumulator: sums LEN unsigned samples through a Brent-Kung adder with a sticky carry flag,
// then holds the result until the consumer handshakes it.
module bk_accum
    import bk_pkg::*;
#(
    parameter int N   = BK_N,
    parameter int LEN = BK_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         ovf,
    output logic         busy
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    state_t           state_r;
    logic [N-1:0]     acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [N-1:0]     add_sum_s;
    logic             add_cout_s;
    logic             accept_s;

    BrentKung_par #(.N(N)) u_adder (
        .A    (acc_r),
        .B    (din),
        .Cin  (1'b0),
        .Sum  (add_sum_s),
        .Cout (add_cout_s)
    );

    assign accept_s = in_valid & in_ready_r;

    // Frame FSM; handshake flags are registered alongside the state so outputs never see inputs combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= {N{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= ACCUM;
                        acc_r      <= {N{1'b0}};
                        cnt_r      <= {CNT_W{1'b0}};
                        ovf_r      <= 1'b0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        acc_r <= add_sum_s;
                        ovf_r <= ovf_r | add_cout_s;
                        if (cnt_r == CNT_LAST) begin
                            state_r     <= DONE;
                            cnt_r       <= {CNT_W{1'b0}};
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = acc_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_bk_accum.sv
// Directed bench for bk_accum (N=16, LEN=4): vector table for basic/overflow frames plus hand sequences.
module tb_bk_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        ovf;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        start;
        logic        iv;
        logic [15:0] din;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic        e_busy;
        logic [15:0] e_sum;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[13];

    bk_accum #(.N(16), .LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ir, input logic ov, input logic bz,
                           input logic [15:0] s, input logic o);
        chk({tag, " in_ready"}, {15'd0, in_ready}, {15'd0, ir});
        chk({tag, " out_valid"}, {15'd0, out_valid}, {15'd0, ov});
        chk({tag, " busy"}, {15'd0, busy}, {15'd0, bz});
        chk({tag, " sum"}, sum, s);
        chk({tag, " ovf"}, {15'd0, ovf}, {15'd0, o});
    endtask

    task automatic cyc(input logic s, input logic v, input logic [15:0] d, input logic r);
        start     = s;
        in_valid  = v;
        din       = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] dat[4];
    logic [15:0] part[4];
    logic [15:0] prev;

    initial begin
        dat  = '{16'h0D0D, 16'h0606, 16'h1111, 16'h2222};
        part = '{16'h0D0D, 16'h1313, 16'h2424, 16'h4646};

        // start, iv, din, ordy | in_ready, out_valid, busy, sum, ovf
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'h0D0D, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0D0D, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'h0606, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1313, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2424, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4646, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4646, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4646, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFD, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFC, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFC, 1'b1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; din = 16'h0000; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < 13; k++) begin
            cyc(tbl[k].start, tbl[k].iv, tbl[k].din, tbl[k].ordy);
            chk_all($sformatf("v%0d", k), tbl[k].e_ir, tbl[k].e_ov, tbl[k].e_busy,
                    tbl[k].e_sum, tbl[k].e_ovf);
        end

        // gaps between samples, with start pulses in ACCUM that must be ignored
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        chk_all("gap start", 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
        prev = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 3; g++) begin
                cyc(g == 1, 1'b0, 16'hFFFF, 1'b0);
                chk_all($sformatf("gap%0d_%0d", k, g), 1'b1, 1'b0, 1'b1, prev, 1'b0);
            end
            cyc(1'b0, 1'b1, dat[k], 1'b0);
            if (k < 3) chk_all($sformatf("gap acc%0d", k), 1'b1, 1'b0, 1'b1, part[k], 1'b0);
            else chk_all("gap done", 1'b0, 1'b1, 1'b1, 16'h4646, 1'b0);
            prev = part[k];
        end

        // backpressure in DONE with start pulses and stray in_valid
        for (int j = 0; j < 5; j++) begin
            cyc(j % 2 == 0, 1'b1, 16'h1111, 1'b0);
            chk_all($sformatf("hold%0d", j), 1'b0, 1'b1, 1'b1, 16'h4646, 1'b0);
        end
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk_all("release", 1'b0, 1'b0, 1'b0, 16'h4646, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        chk_all("no queued start", 1'b0, 1'b0, 1'b0, 16'h4646, 1'b0);

        // reset in the middle of ACCUM after two accepts
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 1'b1, 16'h0D0D, 1'b0);
        cyc(1'b0, 1'b1, 16'h0606, 1'b0);
        chk_all("pre rst", 1'b1, 1'b0, 1'b1, 16'h1313, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("async rst", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b1, 16'h0001, 1'b1);
        chk_all("post rst", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 16'h0001, 1'b0);
            chk_all($sformatf("ones%0d", k), k != 3, k == 3, 1'b1, 16'(k + 1), 1'b0);
        end

        // reset while a result is pending in DONE
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 16'hFFFF, 1'b0);
        chk_all("pre rst done", 1'b0, 1'b1, 1'b1, 16'hFFFC, 1'b1);
        rst = 1'b1;
        #1;
        chk_all("rst in done", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        chk_all("after done rst", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
